// File: rtl/program_ram_loader_if.sv
// CPU-side memory bus for program_ram_loader.
// Master drives address/write; slave returns combinational read data.
interface program_ram_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/program_ram_loader.sv
// Program/data RAM with a debounced front-panel loader (LOAD)
// and a CPU port that owns the memory in RUN.
module program_ram_loader #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_btn,
  input  logic [ADDR_W-1:0]    sw_addr,
  input  logic [DATA_W-1:0]    sw_data,
  input  logic                 auto_inc,
  program_ram_loader_if.slave  cpu,
  output logic [ADDR_W-1:0]    load_ptr,
  output logic                 load_ack,
  output logic                 mem_full,
  output logic                 run_mode
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic             s1, s2;
  logic             btn_db, btn_db_q;
  logic [CNT_W-1:0] db_cnt;
  logic             load_req;
  logic             load_we;
  logic             cpu_wr;
  logic             leave_run;
  logic [ADDR_W-1:0] load_addr;

  // Synchroniser plus stability counter on the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1       <= load_btn;
      s2       <= s1;
      btn_db_q <= btn_db;
      if (s2 != btn_db) begin
        if (db_cnt == CNT_MAX) begin
          btn_db <= ~btn_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign load_req  = btn_db & ~btn_db_q;
  assign load_we   = (state == ST_LOAD) & load_req;
  assign cpu_wr    = (state == ST_RUN) & cpu.we;
  assign leave_run = (state == ST_RUN) & ~start;
  assign load_addr = auto_inc ? load_ptr : sw_addr;
  assign run_mode  = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (!start) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_ptr <= '0;
      mem_full <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= load_we;
      if (leave_run) begin
        load_ptr <= '0;
        mem_full <= 1'b0;
      end else if (load_we && auto_inc) begin
        load_ptr <= load_ptr + 1'b1;
        if (&load_ptr) mem_full <= 1'b1;
      end
    end
  end

  // Loader and CPU writes are exclusive by state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_we) begin
      mem[load_addr] <= sw_data;
    end else if (cpu_wr) begin
      mem[cpu.addr] <= cpu.wdata;
    end
  end

  assign cpu.rdata = mem[cpu.addr];

endmodule
